// File: rtl/mac_row_ctrl.sv
`default_nettype none
// ============================================================================
// mac_row_ctrl : weight-load / activation-stream sequencer for one MAC row
// Revision 1.0
// ============================================================================
module mac_row_ctrl #(
  parameter int bw      = 4,
  parameter int col     = 8,
  parameter int addr_bw = 8,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  num_act,
  output logic               wgt_rd_en,
  output logic [addr_bw-1:0] wgt_addr,
  input  logic [bw-1:0]      wgt_data,
  output logic               act_rd_en,
  output logic [addr_bw-1:0] act_addr,
  input  logic [bw-1:0]      act_data,
  input  logic               ofifo_full,
  input  logic [col-1:0]     valid,
  output logic [bw-1:0]      in_w,
  output logic [1:0]         inst_w,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [cnt_bw-1:0] c_last_col = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0] c_one      = cnt_bw'(1);
  localparam logic [cnt_bw-1:0] c_zero     = '0;

  state_t              state_q, state_d;
  logic [cnt_bw-1:0]   n_q, n_d;
  logic [cnt_bw-1:0]   ic_q, ic_d;
  logic [cnt_bw-1:0]   cc_q, cc_d;
  logic                wpend_q, apend_q;
  logic                unused_valid;

  // Only the last column's valid marks a completed vector.
  assign unused_valid = ^valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      ic_q    <= '0;
      cc_q    <= '0;
      wpend_q <= 1'b0;
      apend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ic_q    <= ic_d;
      cc_q    <= cc_d;
      wpend_q <= wgt_rd_en;
      apend_q <= act_rd_en;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    ic_d      = ic_q;
    cc_d      = cc_q;
    wgt_rd_en = 1'b0;
    wgt_addr  = '0;
    act_rd_en = 1'b0;
    act_addr  = '0;
    busy      = 1'b0;
    done      = 1'b0;

    if ((state_q == S_EXEC || state_q == S_DRAIN) && valid[col-1] && (cc_q != n_q)) begin
      cc_d = cc_q + c_one;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = num_act;
          ic_d    = '0;
          cc_d    = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy      = 1'b1;
        wgt_rd_en = 1'b1;
        wgt_addr  = addr_bw'(ic_q);
        if (ic_q == c_last_col) begin
          ic_d    = '0;
          state_d = (n_q != c_zero) ? S_EXEC : S_DRAIN;
        end else begin
          ic_d = ic_q + c_one;
        end
      end
      S_EXEC: begin
        busy     = 1'b1;
        act_addr = addr_bw'(ic_q);
        // A full output FIFO turns this slot into a bubble; address holds.
        if (!ofifo_full) begin
          act_rd_en = 1'b1;
          ic_d      = ic_q + c_one;
          if (ic_q == n_q - c_one) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cc_d == n_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM data arrives one cycle after the strobe, alongside the delayed strobe.
  assign inst_w = {apend_q, wpend_q};
  assign in_w   = wpend_q ? wgt_data :
                  apend_q ? act_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mac_row_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mac_row_ctrl : directed bench for mac_row_ctrl with SRAM and row models
// Revision 1.0
// ============================================================================
module tb_mac_row_ctrl;

  localparam int BW  = 4;
  localparam int COL = 8;
  localparam int ABW = 8;
  localparam int CBW = 8;
  localparam int TN  = 40;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [CBW-1:0] num_act;
  logic           wgt_rd_en;
  logic [ABW-1:0] wgt_addr;
  logic [BW-1:0]  wgt_data;
  logic           act_rd_en;
  logic [ABW-1:0] act_addr;
  logic [BW-1:0]  act_data;
  logic           ofifo_full;
  logic [COL-1:0] valid;
  logic [BW-1:0]  in_w;
  logic [1:0]     inst_w;
  logic           busy;
  logic           done;

  logic [BW-1:0]  wmem [256];
  logic [BW-1:0]  amem [256];
  logic [2:0]     vpipe = 3'b000;
  logic           vstray;

  int n_checks = 0;
  int n_errors = 0;

  int tr_inst [TN];
  int tr_in   [TN];
  int tr_wen  [TN];
  int tr_waddr[TN];
  int tr_aen  [TN];
  int tr_aaddr[TN];
  int tr_done [TN];
  int tr_busy [TN];

  always #5 clk = ~clk;

  mac_row_ctrl #(.bw(BW), .col(COL), .addr_bw(ABW), .cnt_bw(CBW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .num_act(num_act),
    .wgt_rd_en(wgt_rd_en), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
    .act_rd_en(act_rd_en), .act_addr(act_addr), .act_data(act_data),
    .ofifo_full(ofifo_full), .valid(valid),
    .in_w(in_w), .inst_w(inst_w), .busy(busy), .done(done)
  );

  // SRAMs with one-cycle read latency; row emits valid[COL-1] three cycles after an execute.
  always @(posedge clk) begin
    if (wgt_rd_en) wgt_data <= wmem[wgt_addr];
    if (act_rd_en) act_data <= amem[act_addr];
    vpipe <= {vpipe[1:0], (inst_w == 2'b10)};
  end
  assign valid = {(vpipe[2] | vstray), {(COL-1){1'b0}}};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // t=0 is the first cycle after the edge that accepts start.
  task automatic run_job(input int n, input int st0, input int stlen, input int rs_at);
    @(negedge clk);
    num_act = CBW'(n);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 0; t < TN; t++) begin
      ofifo_full = (t >= st0) && (t < st0 + stlen);
      if (t == rs_at) begin
        start   = 1'b1;
        num_act = CBW'(9);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      tr_inst[t]  = int'(inst_w);
      tr_in[t]    = int'(in_w);
      tr_wen[t]   = int'(wgt_rd_en);
      tr_waddr[t] = int'(wgt_addr);
      tr_aen[t]   = int'(act_rd_en);
      tr_aaddr[t] = int'(act_addr);
      tr_done[t]  = int'(done);
      tr_busy[t]  = int'(busy);
      @(posedge clk);
      #1;
    end
    ofifo_full = 1'b0;
    start      = 1'b0;
    num_act    = '0;
  endtask

  task automatic check_run(input string p, input int n, input int exp_done);
    int first;
    int cnt_d;
    int cnt_a;
    int cnt_w;
    first = -1;
    cnt_d = 0;
    cnt_a = 0;
    cnt_w = 0;
    for (int t = 0; t < TN; t++) begin
      if (tr_done[t] != 0 && first < 0) first = t;
      cnt_d += tr_done[t];
      cnt_a += tr_aen[t];
      cnt_w += tr_wen[t];
    end
    check({p, "_done_t"}, first, exp_done);
    check({p, "_done_cnt"}, cnt_d, 1);
    check({p, "_act_reads"}, cnt_a, n);
    check({p, "_wgt_reads"}, cnt_w, COL);
    check({p, "_busy_pre"}, tr_busy[exp_done-1], 1);
    check({p, "_busy_post"}, tr_busy[exp_done+1], 0);
    check({p, "_inst_t0"}, tr_inst[0], 0);
    for (int t = 0; t < COL; t++) begin
      check({p, "_ld_addr"}, (tr_wen[t] != 0) ? tr_waddr[t] : -1, t);
      check({p, "_ld_inst_in"}, tr_inst[t+1] * 100 + tr_in[t+1], 100 + t + 1);
    end
  endtask

  initial begin
    int exp_act[4];
    int exp_stall[6];
    exp_act   = '{3, 5, 7, 9};
    exp_stall = '{2, 2, 0, 0, 2, 2};

    for (int i = 0; i < 256; i++) begin
      wmem[i] = BW'(i + 1);
      amem[i] = '0;
    end
    for (int i = 0; i < 4; i++) amem[i] = BW'(exp_act[i]);

    reset      = 1'b0;
    start      = 1'b0;
    num_act    = '0;
    ofifo_full = 1'b0;
    vstray     = 1'b0;

    #2;
    check("rst_wgt_rd_en", int'(wgt_rd_en), 0);
    check("rst_wgt_addr",  int'(wgt_addr),  0);
    check("rst_act_rd_en", int'(act_rd_en), 0);
    check("rst_act_addr",  int'(act_addr),  0);
    check("rst_in_w",      int'(in_w),      0);
    check("rst_inst_w",    int'(inst_w),    0);
    check("rst_busy",      int'(busy),      0);
    check("rst_done",      int'(done),      0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic run
    run_job(4, -1, 0, -1);
    check_run("basic", 4, 16);
    for (int t = 0; t < 4; t++) begin
      check("basic_exec_inst_in", tr_inst[9+t] * 100 + tr_in[9+t], 200 + exp_act[t]);
      check("basic_act_addr", tr_aaddr[8+t], t);
    end
    check("basic_inst_after", tr_inst[13], 0);

    // Two-cycle output FIFO stall after the second activation read
    run_job(4, 10, 2, -1);
    check_run("stall", 4, 18);
    for (int t = 0; t < 6; t++) begin
      check("stall_inst_seq", tr_inst[9+t], exp_stall[t]);
    end
    check("stall_aen_10", tr_aen[10], 0);
    check("stall_aen_11", tr_aen[11], 0);
    check("stall_addr_10", tr_aaddr[10], 2);
    check("stall_addr_11", tr_aaddr[11], 2);
    check("stall_addr_12", tr_aaddr[12], 2);

    // Zero activations
    run_job(0, -1, 0, -1);
    check_run("n0", 0, 9);
    check("n0_inst_after", tr_inst[9], 0);

    // start pulsed with num_act=9 during EXEC
    run_job(4, -1, 0, 10);
    check_run("busy_start", 4, 16);
    check("busy_start_idle_after", tr_busy[20], 0);

    // Asynchronous reset in the middle of the weight load
    @(negedge clk);
    num_act = CBW'(4);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mr_addr_before", int'(wgt_addr), 3);
    check("mr_inst_before", int'(inst_w), 1);
    #2;
    reset = 1'b0;
    #1;
    check("mr_wgt_rd_en", int'(wgt_rd_en), 0);
    check("mr_wgt_addr",  int'(wgt_addr),  0);
    check("mr_inst_w",    int'(inst_w),    0);
    check("mr_in_w",      int'(in_w),      0);
    check("mr_busy",      int'(busy),      0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_idle_busy", int'(busy), 0);
    run_job(4, -1, 0, -1);
    check_run("mr_restart", 4, 16);

    // Stray completion pulse while idle
    @(negedge clk);
    vstray = 1'b1;
    @(negedge clk);
    vstray = 1'b0;
    run_job(2, -1, 0, -1);
    check_run("stray", 2, 14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
